// File: rtl/fprint_compare_rx.sv
// -----------------------------------------------------------------------------
// fprint_compare_rx
//   Comparator-side receiver for fingerprint traffic. Two Avalon-MM write-only
//   slave ports (core 0 / core 1) each feed a small FIFO of {task id,
//   fingerprint} entries. Entries are paired strictly in arrival order and
//   compared by a three-state FSM (IDLE -> LOAD -> CHECK). Each comparison
//   gives a one-cycle result pulse. A mismatch raises a sticky irq.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   sN_write/address/writedata   core N write request (N = 0, 1)
//   sN_waitrequest            core N FIFO full (registered)
//   irq_ack                   clears irq and timeout
//   result_valid/match/task   one-cycle comparison result
//   mismatch_task             task id of first unacknowledged mismatch
//   match_count               matched-pair counter (wraps)
//   irq, timeout              sticky error flags
//
// Configuration
//   FPRINT_CMP_TIMEOUT_EN     when defined, an entry left unpaired for
//                             TIMEOUT_CYCLES cycles sets timeout and irq
//                             and flushes both FIFOs. When undefined,
//                             timeout is tied 0.
// -----------------------------------------------------------------------------
module fprint_compare_rx #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 27,
    parameter int TASK_BITS      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_write,
    input  logic [ADDR_WIDTH-1:0] s0_address,
    input  logic [DATA_WIDTH-1:0] s0_writedata,
    output logic                  s0_waitrequest,
    input  logic                  s1_write,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic [DATA_WIDTH-1:0] s1_writedata,
    output logic                  s1_waitrequest,
    input  logic                  irq_ack,
    output logic                  result_valid,
    output logic                  result_match,
    output logic [TASK_BITS-1:0]  result_task,
    output logic [TASK_BITS-1:0]  mismatch_task,
    output logic [15:0]           match_count,
    output logic                  irq,
    output logic                  timeout
);

    localparam int EW = TASK_BITS + DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

    state_t         state_q, state_d;
    logic           pop;
    logic           flush;
    logic [1:0]     wr;
    logic [1:0]     full;
    logic [1:0]     empty;
    logic [EW-1:0]  entry [2];
    logic [EW-1:0]  head  [2];

    assign wr[0]    = s0_write;
    assign wr[1]    = s1_write;
    assign entry[0] = {s0_address[TASK_BITS+1:2], s0_writedata};
    assign entry[1] = {s1_address[TASK_BITS+1:2], s1_writedata};

    // Only the task-id field of the address is used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s0_address[ADDR_WIDTH-1:TASK_BITS+2], s0_address[1:0],
                                s1_address[ADDR_WIDTH-1:TASK_BITS+2], s1_address[1:0]};

    // ---------------------------------------------------------------- FIFOs
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          full_q;
        logic          push;

        // Gated by the registered full flag, so a pop in the same cycle
        // never makes room for a push.
        assign push = wr[g] && !full_q;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end

        // NOTE: storage has no reset; only pointers and count define validity,
        // which keeps the array as plain RAM.
        always_ff @(posedge clk) begin
            if (push) mem_q[wptr_q] <= entry[g];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                full_q <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
                cnt_q  <= cnt_d;
                full_q <= (cnt_d == CW'(FIFO_DEPTH));
            end
        end

        assign full[g]  = full_q;
        assign empty[g] = (cnt_q == '0);
        assign head[g]  = mem_q[rptr_q];
    end

    assign s0_waitrequest = full[0];
    assign s1_waitrequest = full[1];

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE:  if (!empty[0] && !empty[1]) state_d = S_LOAD;
            S_LOAD: begin
                pop     = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------- compare / results
    logic [EW-1:0]        cmp0_q, cmp1_q;
    logic                 check, is_match, timeout_fire;
    logic                 res_valid_q, res_match_q, irq_q, irq_d;
    logic [TASK_BITS-1:0] res_task_q, mm_task_q, mm_task_d;
    logic [15:0]          match_cnt_q;

    assign check    = (state_q == S_CHECK);
    // Whole-entry equality covers both the task id and the fingerprint.
    assign is_match = (cmp0_q == cmp1_q);
    assign flush    = timeout_fire;

    always_comb begin
        irq_d     = irq_q;
        mm_task_d = mm_task_q;
        if (irq_ack) irq_d = 1'b0;
        // A new error in the same cycle as an acknowledge wins.
        if ((check && !is_match) || timeout_fire) irq_d = 1'b1;
        if (check && !is_match && !irq_q) mm_task_d = cmp0_q[EW-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmp0_q      <= '0;
            cmp1_q      <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_task_q  <= '0;
            mm_task_q   <= '0;
            match_cnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= check;
            irq_q       <= irq_d;
            mm_task_q   <= mm_task_d;
            if (pop) begin
                cmp0_q <= head[0];
                cmp1_q <= head[1];
            end
            if (check) begin
                res_match_q <= is_match;
                res_task_q  <= cmp0_q[EW-1:DATA_WIDTH];
                if (is_match) match_cnt_q <= match_cnt_q + 16'd1;
            end
        end
    end

    assign result_valid  = res_valid_q;
    assign result_match  = res_match_q;
    assign result_task   = res_task_q;
    assign mismatch_task = mm_task_q;
    assign match_count   = match_cnt_q;
    assign irq           = irq_q;

    // -------------------------------------------------------------- timeout
`ifdef FPRINT_CMP_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
    logic        tmo_run;

    // Counts only while one side waits for a partner and no compare is busy.
    assign tmo_run      = (empty[0] ^ empty[1]) && (state_q == S_IDLE);
    assign timeout_fire = tmo_run && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = '0;
        if (tmo_run && !timeout_fire) tmo_cnt_d = tmo_cnt_q + 16'd1;
        timeout_d = timeout_q;
        if (irq_ack)      timeout_d = 1'b0;
        if (timeout_fire) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign timeout      = 1'b0;

    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_fprint_compare_rx.sv
module tb_fprint_compare_rx;

    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_write, s1_write;
    logic [26:0] s0_address, s1_address;
    logic [31:0] s0_writedata, s1_writedata;
    logic        s0_waitrequest, s1_waitrequest;
    logic        irq_ack;
    logic        result_valid, result_match;
    logic [3:0]  result_task, mismatch_task;
    logic [15:0] match_count;
    logic        irq, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Result monitor
    int         rv_cnt   = 0;
    int         rv_match = 0;
    logic       last_match;
    logic [3:0] last_task;

    always #5 clk = ~clk;

    fprint_compare_rx #(
        .DATA_WIDTH(32), .ADDR_WIDTH(27), .TASK_BITS(4),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_write(s0_write), .s0_address(s0_address),
        .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
        .s1_write(s1_write), .s1_address(s1_address),
        .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .irq_ack(irq_ack),
        .result_valid(result_valid), .result_match(result_match),
        .result_task(result_task), .mismatch_task(mismatch_task),
        .match_count(match_count), .irq(irq), .timeout(timeout)
    );

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_cnt++;
            if (result_match === 1'b1) rv_match++;
            last_match = result_match;
            last_task  = result_task;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s0_write = 1'b0; s1_write = 1'b0; irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rv_cnt = 0; rv_match = 0;
    endtask

    // Issue n writes on port p, honouring waitrequest (bounded wait per write).
    task automatic burst(input int p, input int n, input logic [26:0] a, input logic [31:0] d);
        int  waited;
        bit  stuck;
        stuck = 1'b0;
        for (int k = 0; k < n && !stuck; k++) begin
            @(negedge clk);
            if (p == 0) begin s0_write = 1'b1; s0_address = a; s0_writedata = d; end
            else        begin s1_write = 1'b1; s1_address = a; s1_writedata = d; end
            waited = 0;
            while (((p == 0) ? s0_waitrequest : s1_waitrequest) && waited < BUDGET) begin
                @(negedge clk);
                waited++;
            end
            if ((p == 0) ? s0_waitrequest : s1_waitrequest) begin
                n_checks++;
                $display("FAIL burst_wait: port %0d write %0d still blocked after %0d cycles", p, k, BUDGET);
                stuck = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk);
        if (p == 0) s0_write = 1'b0; else s1_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s0_write = 1'b0; s1_write = 1'b0; irq_ack = 1'b0;
        s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({result_valid, result_match, result_task, mismatch_task, match_count, irq, timeout,
             s0_waitrequest, s1_waitrequest} !== '0)
            $display("FAIL reset_outputs: got rv=%0b m=%0b t=%0d mt=%0d mc=%0d irq=%0b to=%0b w0=%0b w1=%0b expected all 0",
                     result_valid, result_match, result_task, mismatch_task, match_count, irq, timeout,
                     s0_waitrequest, s1_waitrequest);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_pair_match();
        @(negedge clk);
        s0_write = 1'b1; s0_address = 27'h0C; s0_writedata = 32'h12345678;
        s1_write = 1'b1; s1_address = 27'h0C; s1_writedata = 32'h12345678;
        @(posedge clk);                     // edge E
        @(negedge clk);
        s0_write = 1'b0; s1_write = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0) $display("FAIL match_early: E+%0d result_valid got %0b expected 0", c, result_valid);
            else n_pass++;
        end
        @(posedge clk); @(negedge clk);     // after E+3
        n_checks++;
        if (result_valid !== 1'b1) $display("FAIL match_latency: result_valid got %0b expected 1", result_valid);
        else n_pass++;
        n_checks++;
        if (result_match !== 1'b1) $display("FAIL match_flag: got %0b expected 1", result_match);
        else n_pass++;
        n_checks++;
        if (result_task !== 4'd3) $display("FAIL match_task: got %0d expected 3", result_task);
        else n_pass++;
        n_checks++;
        if (match_count !== 16'd1) $display("FAIL match_count: got %0d expected 1", match_count);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL match_irq: got %0b expected 0", irq);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0) $display("FAIL match_pulse: result_valid got %0b expected 0 one cycle later", result_valid);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        fork
            burst(0, 1, 27'h14, 32'hDEADBEEF);
            burst(1, 1, 27'h14, 32'hDEADBEEE);
        join
        repeat (5) @(negedge clk);
        n_checks++;
        if (last_match !== 1'b0 || last_task !== 4'd5)
            $display("FAIL mm_result: got match=%0b task=%0d expected match=0 task=5", last_match, last_task);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL mm_irq: got %0b expected 1", irq);
        else n_pass++;
        n_checks++;
        if (mismatch_task !== 4'd5) $display("FAIL mm_task: got %0d expected 5", mismatch_task);
        else n_pass++;
        fork
            burst(0, 1, 27'h18, 32'h1);
            burst(1, 1, 27'h18, 32'h2);
        join
        repeat (5) @(negedge clk);
        n_checks++;
        if (last_task !== 4'd6 || last_match !== 1'b0)
            $display("FAIL mm2_result: got match=%0b task=%0d expected match=0 task=6", last_match, last_task);
        else n_pass++;
        n_checks++;
        if (mismatch_task !== 4'd5) $display("FAIL mm_first_kept: got %0d expected 5", mismatch_task);
        else n_pass++;
        irq_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL mm_ack: irq got %0b expected 0", irq);
        else n_pass++;
        n_checks++;
        if (match_count !== 16'd1) $display("FAIL mm_count: match_count got %0d expected 1", match_count);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        int rv0;
        rv0 = rv_cnt;
        fork
            burst(0, 5, 27'h1C, 32'hA5A50000);
            begin
                repeat (6) @(negedge clk);
                n_checks++;
                if (s0_waitrequest !== 1'b1) $display("FAIL bp_full: s0_waitrequest got %0b expected 1", s0_waitrequest);
                else n_pass++;
                n_checks++;
                if (rv_cnt !== rv0) $display("FAIL bp_no_result: results got %0d expected 0", rv_cnt - rv0);
                else n_pass++;
                burst(1, 5, 27'h1C, 32'hA5A50000);
            end
        join
        repeat (30) @(negedge clk);
        n_checks++;
        if (rv_cnt - rv0 !== 5) $display("FAIL bp_results: got %0d expected 5", rv_cnt - rv0);
        else n_pass++;
        n_checks++;
        if (match_count !== 16'd6) $display("FAIL bp_count: match_count got %0d expected 6", match_count);
        else n_pass++;
        n_checks++;
        if (s0_waitrequest !== 1'b0) $display("FAIL bp_drained: s0_waitrequest got %0b expected 0", s0_waitrequest);
        else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        fork
            burst(0, 10000, 27'h0, 32'h1);
            burst(1, 10000, 27'h0, 32'h1);
        join
        repeat (20) @(negedge clk);
        n_checks++;
        if (rv_cnt !== 10000) $display("FAIL stream_results: got %0d expected 10000", rv_cnt);
        else n_pass++;
        n_checks++;
        if (rv_match !== 10000) $display("FAIL stream_matches: got %0d expected 10000", rv_match);
        else n_pass++;
        n_checks++;
        if (match_count !== 16'd10000) $display("FAIL stream_count: got %0d expected 10000", match_count);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL stream_irq: got %0b expected 0", irq);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        burst(0, 1, 27'h04, 32'h55);        // returns at the negedge after acceptance
`ifdef FPRINT_CMP_TIMEOUT_EN
        repeat (15) @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL tmo_early: timeout got %0b expected 0 at cycle 15", timeout);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b1 || irq !== 1'b1)
            $display("FAIL tmo_fire: got timeout=%0b irq=%0b expected 1 1 at cycle 16", timeout, irq);
        else n_pass++;
        burst(1, 1, 27'h04, 32'h55);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rv_cnt !== 0) $display("FAIL tmo_flush: results got %0d expected 0", rv_cnt);
        else n_pass++;
`else
        repeat (1000) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0 || timeout !== 1'b0)
            $display("FAIL tmo_disabled: got irq=%0b timeout=%0b expected 0 0", irq, timeout);
        else n_pass++;
        n_checks++;
        if (rv_cnt !== 0) $display("FAIL tmo_unpaired: results got %0d expected 0", rv_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_op();
        int rv0;
        do_reset();
        fork
            burst(0, 1, 27'h08, 32'h1);
            burst(1, 1, 27'h08, 32'h0);
        join
        fork
            burst(0, 1, 27'h04, 32'h9);
            burst(1, 1, 27'h04, 32'h9);
        join
        repeat (6) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1 || match_count !== 16'd1)
            $display("FAIL rmo_setup: got irq=%0b match_count=%0d expected 1 1", irq, match_count);
        else n_pass++;
        burst(0, 2, 27'h0, 32'h7);
        @(negedge clk);
        s1_write = 1'b1; s1_address = 27'h0; s1_writedata = 32'h7;
        @(posedge clk);                     // edge E: pair available
        @(negedge clk);
        s1_write = 1'b0;
        @(posedge clk);                     // E+1: FSM now in LOAD
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({result_valid, result_match, result_task, mismatch_task, match_count, irq, timeout,
             s0_waitrequest, s1_waitrequest} !== '0)
            $display("FAIL rmo_outputs: got rv=%0b m=%0b t=%0d mt=%0d mc=%0d irq=%0b to=%0b expected all 0",
                     result_valid, result_match, result_task, mismatch_task, match_count, irq, timeout);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        rv0 = rv_cnt;
        burst(1, 1, 27'h0, 32'h7);
        repeat (20) @(negedge clk);
        n_checks++;
        if (rv_cnt !== rv0) $display("FAIL rmo_fifo_empty: results got %0d expected 0", rv_cnt - rv0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pair_match();
        test_mismatch();
        test_back_pressure();
        test_stream();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
